instr_dcd: RTL and testbench

- Command decoder directly downstream of the SPI byte bridge: consumes the received byte stream (byte_sync/data_in) and supplies the next byte to shift out (data_out).
- Parses each frame as a command byte followed by one data byte, or by a burst of data bytes.
- Converts frames into single-cycle read/write strobes on the PWM register file.
- Sits between the SPI bridge and the register bank, all in the clk domain.

---
 rtl/instr_dcd.sv | 135 +++++++++++++
 tb/tb_instr_dcd.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dcd.sv
// SPI command decoder: turns command/data byte frames from the SPI byte bridge
// into single-cycle read/write strobes on the register file and sources read data.
module instr_dcd #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    typedef enum logic {ST_CMD = 1'b0, ST_DATA = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                cs_s1_q, cs_s2_q;
    logic                burst_q, burst_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                reg_wr_q, reg_wr_d;
    logic                reg_rd_q, reg_rd_d;
    logic                rd_cap_q, rd_cap_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                deselected;

    assign deselected = cs_s2_q;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            state_q    <= ST_CMD;
            burst_q    <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            reg_wr_q   <= 1'b0;
            reg_rd_q   <= 1'b0;
            rd_cap_q   <= 1'b0;
            wdata_q    <= '0;
            dout_q     <= '0;
        end else begin
            cs_s1_q    <= cs_n;
            cs_s2_q    <= cs_s1_q;
            state_q    <= state_d;
            burst_q    <= burst_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            reg_wr_q   <= reg_wr_d;
            reg_rd_q   <= reg_rd_d;
            rd_cap_q   <= rd_cap_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (deselected) begin
            state_d = ST_CMD;
        end else if (byte_sync) begin
            case (state_q)
                ST_CMD:  state_d = ST_DATA;
                ST_DATA: state_d = burst_q ? ST_DATA : ST_CMD;
                default: state_d = ST_CMD;
            endcase
        end
    end

    // Strobe, address and data generation
    always_comb begin
        burst_d    = burst_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        reg_wr_d   = 1'b0;
        reg_rd_d   = 1'b0;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        // Register file answers one clk after the read strobe; capture it then.
        rd_cap_d   = reg_rd_q;
        if (rd_cap_q) begin
            dout_d = reg_rdata;
        end
        // Write bursts advance the address once the strobe has been seen.
        if (reg_wr_q && burst_q) begin
            addr_d = addr_q + 1'b1;
        end
        if (deselected) begin
            burst_d = 1'b0;
        end else if (byte_sync) begin
            case (state_q)
                ST_CMD: begin
                    is_write_d = data_in[7];
                    burst_d    = data_in[6];
                    addr_d     = data_in[ADDR_W-1:0];
                    if (data_in[7]) begin
                        dout_d = '0;
                    end else begin
                        reg_rd_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (is_write_q) begin
                        reg_wr_d = 1'b1;
                        wdata_d  = data_in;
                    end else if (burst_q) begin
                        // Read bursts prefetch the next address; the dummy byte is dropped.
                        addr_d   = addr_q + 1'b1;
                        reg_rd_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        data_out  = dout_q;
        reg_addr  = addr_q;
        reg_wr    = reg_wr_q;
        reg_rd    = reg_rd_q;
        reg_wdata = wdata_q;
    end

endmodule

// File: tb/tb_instr_dcd.sv
// Directed bench for instr_dcd: table of single frames plus burst/abort/reset sequences
// against a small behavioural register file.
module tb_instr_dcd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [5:0] reg_addr;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mem [64];
    logic [13:0] wr_log [$];
    logic [5:0]  rd_log [$];
    logic        both_seen = 1'b0;

    instr_dcd #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .byte_sync(byte_sync),
        .data_in(data_in), .data_out(data_out), .reg_addr(reg_addr),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    // Register file model: write on strobe, read data valid the clk after reg_rd
    always @(posedge clk) begin
        if (reg_wr) mem[reg_addr] <= reg_wdata;
        if (reg_rd) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
        if (reg_rd) rd_log.push_back(reg_addr);
        if (reg_wr && reg_rd) both_seen = 1'b1;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic       exp_wr;
        logic [5:0] exp_addr;
        logic [7:0] exp_wdata;
        logic       exp_rd;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one byte_sync pulse; sample strobes 1 clk after and data_out 1 and 2 clk after.
    task automatic send_byte(input logic [7:0] b, output logic wr1, output logic rd1,
                             output logic [7:0] dout1, output logic [7:0] dout2);
        @(negedge clk);
        data_in   = b;
        byte_sync = 1'b1;
        @(negedge clk);
        byte_sync = 1'b0;
        wr1 = reg_wr;
        rd1 = reg_rd;
        @(negedge clk);
        dout1 = data_out;
        @(negedge clk);
        dout2 = data_out;
        idle(14);
    endtask

    task automatic send(input logic [7:0] b);
        logic w, r;
        logic [7:0] d1, d2;
        send_byte(b, w, r, d1, d2);
    endtask

    task automatic select();
        @(negedge clk);
        cs_n = 1'b0;
        idle(4);
    endtask

    task automatic deselect();
        @(negedge clk);
        cs_n = 1'b1;
        idle(4);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
    endtask

    initial begin
        logic       w, r;
        logic [7:0] d1, d2;
        logic [7:0] prev_dout;

        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3);
        mem[8'h0A] = 8'h5A;
        mem[2]     = 8'h77;

        vecs[0] = '{cmd: 8'h85, dat: 8'h3C, exp_wr: 1'b1, exp_addr: 6'd5,  exp_wdata: 8'h3C, exp_rd: 1'b0, exp_dout: 8'h00};
        vecs[1] = '{cmd: 8'h0A, dat: 8'h00, exp_wr: 1'b0, exp_addr: 6'h0A, exp_wdata: 8'h00, exp_rd: 1'b1, exp_dout: 8'h5A};
        vecs[2] = '{cmd: 8'hBF, dat: 8'hC3, exp_wr: 1'b1, exp_addr: 6'd63, exp_wdata: 8'hC3, exp_rd: 1'b0, exp_dout: 8'h00};
        vecs[3] = '{cmd: 8'h05, dat: 8'hFF, exp_wr: 1'b0, exp_addr: 6'd5,  exp_wdata: 8'h00, exp_rd: 1'b1, exp_dout: 8'h3C};
        vecs[4] = '{cmd: 8'h3F, dat: 8'h00, exp_wr: 1'b0, exp_addr: 6'd63, exp_wdata: 8'h00, exp_rd: 1'b1, exp_dout: 8'hC3};

        // Reset state
        idle(3);
        check("reset data_out", data_out, 8'h00);
        check("reset reg_addr", reg_addr, 6'd0);
        check("reset reg_wr", reg_wr, 1'b0);
        check("reset reg_rd", reg_rd, 1'b0);
        check("reset reg_wdata", reg_wdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        prev_dout = 8'h00;
        for (int i = 0; i < 5; i++) begin
            clear_logs();
            select();
            send_byte(vecs[i].cmd, w, r, d1, d2);
            check($sformatf("vec%0d rd strobe", i), r, vecs[i].exp_rd);
            check($sformatf("vec%0d wr after cmd", i), w, 1'b0);
            if (vecs[i].exp_rd) begin
                check($sformatf("vec%0d dout early", i), d1, prev_dout);
            end
            check($sformatf("vec%0d dout", i), d2, vecs[i].exp_dout);
            send_byte(vecs[i].dat, w, r, d1, d2);
            check($sformatf("vec%0d wr strobe", i), w, vecs[i].exp_wr);
            deselect();
            check($sformatf("vec%0d wr count", i), wr_log.size(), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d rd count", i), rd_log.size(), 32'(vecs[i].exp_rd));
            if (vecs[i].exp_wr && wr_log.size() > 0)
                check($sformatf("vec%0d wr addr/data", i), wr_log[0],
                      {vecs[i].exp_addr, vecs[i].exp_wdata});
            if (vecs[i].exp_rd && rd_log.size() > 0)
                check($sformatf("vec%0d rd addr", i), rd_log[0], vecs[i].exp_addr);
            prev_dout = vecs[i].exp_dout;
        end

        // Burst write wrapping 63 -> 0
        clear_logs();
        select();
        send(8'hFE); send(8'h11); send(8'h22); send(8'h33);
        deselect();
        check("bwr count", wr_log.size(), 3);
        check("bwr rd count", rd_log.size(), 0);
        if (wr_log.size() == 3) begin
            check("bwr 0", wr_log[0], {6'd62, 8'h11});
            check("bwr 1", wr_log[1], {6'd63, 8'h22});
            check("bwr 2", wr_log[2], {6'd0,  8'h33});
        end
        check("bwr mem0", mem[0], 8'h33);

        // Burst read
        mem[3] = 8'hA1; mem[4] = 8'hA2; mem[5] = 8'hA3; mem[6] = 8'hA6;
        clear_logs();
        select();
        send_byte(8'h43, w, r, d1, d2);
        check("brd dout0", d2, 8'hA1);
        send_byte(8'h00, w, r, d1, d2);
        check("brd dout1 early", d1, 8'hA1);
        check("brd dout1", d2, 8'hA2);
        send_byte(8'h00, w, r, d1, d2);
        check("brd dout2", d2, 8'hA3);
        send_byte(8'h00, w, r, d1, d2);
        check("brd dout3", d2, 8'hA6);
        deselect();
        check("brd dout hold", data_out, 8'hA6);
        check("brd rd count", rd_log.size(), 4);
        check("brd wr count", wr_log.size(), 0);
        if (rd_log.size() == 4) begin
            check("brd addr0", rd_log[0], 6'd3);
            check("brd addr1", rd_log[1], 6'd4);
            check("brd addr2", rd_log[2], 6'd5);
            check("brd addr3", rd_log[3], 6'd6);
        end

        // Abort mid-frame
        clear_logs();
        select();
        send(8'h81);
        deselect();
        select();
        send_byte(8'h02, w, r, d1, d2);
        check("abort dout", d2, 8'h77);
        send(8'h00);
        deselect();
        check("abort wr count", wr_log.size(), 0);
        check("abort rd count", rd_log.size(), 1);
        if (rd_log.size() == 1) check("abort rd addr", rd_log[0], 6'd2);

        // Async reset during a read burst, while a read strobe is high
        select();
        send(8'h4A);
        @(negedge clk);
        data_in   = 8'h00;
        byte_sync = 1'b1;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
        check("pre-reset rd", reg_rd, 1'b1);
        check("pre-reset addr", reg_addr, 6'h0B);
        rst_n = 1'b0;
        #1;
        check("mid reset data_out", data_out, 8'h00);
        check("mid reset reg_addr", reg_addr, 6'd0);
        check("mid reset reg_rd", reg_rd, 1'b0);
        check("mid reset reg_wr", reg_wr, 1'b0);
        check("mid reset reg_wdata", reg_wdata, 8'h00);
        idle(2);
        rst_n = 1'b1;
        clear_logs();
        idle(5);
        send_byte(8'h0A, w, r, d1, d2);
        check("post-reset rd", r, 1'b1);
        check("post-reset dout", d2, 8'h5A);
        send(8'h00);
        deselect();
        check("post-reset rd count", rd_log.size(), 1);
        if (rd_log.size() == 1) check("post-reset rd addr", rd_log[0], 6'h0A);
        check("post-reset wr count", wr_log.size(), 0);

        check("wr/rd overlap", both_seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
